// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared sizing constants and helpers for the register-file
//               read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

  localparam int C_NREQ   = 4;
  localparam int C_AW     = 5;
  localparam int C_DW     = 32;
  localparam int C_PTRW   = $clog2(C_NREQ);
  localparam int C_MAXREQ = 8;

  // Wide enough for the largest supported requester count; callers size-cast down.
  function automatic logic [C_MAXREQ-1:0] onehot(input int idx);
    logic [C_MAXREQ-1:0] v;
    v = C_MAXREQ'(1) << idx;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first eligible index at or
//               after ptr, wrapping from NREQ-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = C_NREQ,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PTRW-1:0] ptr,
  output logic [PTRW-1:0] win,
  output logic            any
);

  // Walk offsets from farthest to nearest so the closest eligible index wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[(int'(ptr) + i) % NREQ]) begin
        win = PTRW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin sharing of the register file's single read mux,
//               with registered select and a one-cycle data capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = C_NREQ,
  parameter int AW   = C_AW,
  parameter int DW   = C_DW
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     mux_a,
  input  logic [DW-1:0]     mux_dout,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0] r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [AW-1:0]   r_mux_a;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic [NREQ-1:0] w_elig;
  logic [PTRW-1:0] w_win;
  logic            w_any;
  logic [NREQ-1:0] w_oh;
  logic [PTRW-1:0] w_ptr_nxt;
  logic [AW-1:0]   w_addr_sel;

  // The requester holding the current grant sits out this round.
  assign w_elig = req & ~r_gnt;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .elig (w_elig),
    .ptr  (r_ptr),
    .win  (w_win),
    .any  (w_any)
  );

  assign w_oh       = NREQ'(onehot(int'(w_win)));
  assign w_ptr_nxt  = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  assign w_addr_sel = addr[int'(w_win)*AW +: AW];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_mux_a  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_any) begin
        r_gnt   <= w_oh;
        r_ptr   <= w_ptr_nxt;
        r_mux_a <= w_addr_sel;
      end else begin
        r_gnt   <= '0;
      end

      // mux_dout reflects r_mux_a, so this lands one cycle behind the grant.
      if (|r_gnt) begin
        r_rvalid <= r_gnt;
        r_rdata  <= mux_dout;
      end else begin
        r_rvalid <= '0;
      end
    end
  end

  assign gnt    = r_gnt;
  assign mux_a  = r_mux_a;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_arbiter
// Description : Directed self-checking bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     mux_a;
  logic [DW-1:0]     mux_dout;
  logic [NREQ-1:0]   rvalid;
  logic [DW-1:0]     rdata;

  int n_pass  = 0;
  int n_total = 0;

  regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .mux_a    (mux_a),
    .mux_dout (mux_dout),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  // Register-file read mux stand-in.
  assign mux_dout = 32'hA5A5_0000 | {{(DW-AW){1'b0}}, mux_a};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: winner index, pointer, and the read in flight.
  int              m_ptr = 0;
  int              m_gi  = -1;
  int              m_ri  = -1;
  logic [AW-1:0]   m_a   = '0;
  logic [DW-1:0]   m_d   = '0;

  function automatic logic [NREQ-1:0] vec(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_ptr = 0; m_gi = -1; m_ri = -1; m_a = '0; m_d = '0;
    end else begin
      int w;
      w = -1;
      if (m_gi >= 0) begin
        m_ri = m_gi;
        m_d  = 32'hA5A5_0000 | {{(DW-AW){1'b0}}, m_a};
      end else begin
        m_ri = -1;
      end
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req[idx] && idx != m_gi) w = idx;
      end
      if (w >= 0) begin
        m_gi  = w;
        m_ptr = (w + 1) % NREQ;
        m_a   = addr[w*AW +: AW];
      end else begin
        m_gi = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (clr === 1'b0) begin
      chk("model gnt",    32'(gnt),    32'(vec(m_gi)));
      chk("model mux_a",  32'(mux_a),  32'(m_a));
      chk("model rvalid", 32'(rvalid), 32'(vec(m_ri)));
      chk("model rdata",  rdata,       m_d);
    end
  end

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr  = 1'b1;
    req  = '0;
    addr = '0;
    repeat (2) @(negedge clk);
    chk("reset gnt",    32'(gnt),    32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset mux_a",  32'(mux_a),  32'h0);
    chk("reset rdata",  rdata,       32'h0);
    clr = 1'b0;

    // Single read of r17.
    addr[0*AW +: AW] = 5'd17;
    req = 4'b0001;
    @(negedge clk);
    chk("single gnt",   32'(gnt),   32'h1);
    chk("single mux_a", 32'(mux_a), 32'd17);
    req = '0;
    @(negedge clk);
    chk("single rvalid", 32'(rvalid), 32'h1);
    chk("single rdata",  rdata,       32'hA5A5_0011);
    idle(2);

    // Clear with a grant in flight.
    addr[1*AW +: AW] = 5'd5;
    req = 4'b0010;
    @(negedge clk);
    chk("inflight gnt", 32'(gnt), 32'h2);
    req = '0;
    #2 clr = 1'b1;
    #1;
    chk("clr gnt",    32'(gnt),    32'h0);
    chk("clr rvalid", 32'(rvalid), 32'h0);
    chk("clr mux_a",  32'(mux_a),  32'h0);
    chk("clr rdata",  rdata,       32'h0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post-clr rvalid", 32'(rvalid), 32'h0);
    end
    addr[3*AW +: AW] = 5'd7;
    req = 4'b1010;
    @(negedge clk);
    chk("first after clr", 32'(gnt), 32'h2);
    req = req & ~gnt;
    @(negedge clk);
    chk("second after clr", 32'(gnt), 32'h8);
    idle(2);

    // All four at once, pointer back at 0.
    addr = {5'd4, 5'd3, 5'd2, 5'd1};
    req  = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("all4 gnt", 32'(gnt), (k <= 4) ? (32'd1 << (k - 1)) : 32'd0);
      if (k >= 2) begin
        chk("all4 rvalid", 32'(rvalid), 32'd1 << (k - 2));
        chk("all4 rdata",  rdata,       32'hA5A5_0000 | 32'(k - 1));
      end
      req = req & ~gnt;
    end
    idle(2);

    // Two requesters held continuously alternate.
    addr[0*AW +: AW] = 5'd10;
    addr[3*AW +: AW] = 5'd13;
    req = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("fair gnt", 32'(gnt), (k % 2 == 1) ? 32'h1 : 32'h8);
    end
    idle(3);

    // Held request is masked every other cycle.
    addr[2*AW +: AW] = 5'd9;
    req = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("mask gnt",    32'(gnt),    (k % 2 == 1) ? 32'h4 : 32'h0);
      chk("mask rvalid", 32'(rvalid), (k % 2 == 0) ? 32'h4 : 32'h0);
    end
    idle(3);

    // Idle after a read of r30 holds select and data.
    addr[1*AW +: AW] = 5'd30;
    req = 4'b0010;
    @(negedge clk);
    chk("idle pre gnt", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    chk("idle pre rvalid", 32'(rvalid), 32'h2);
    repeat (3) begin
      @(negedge clk);
      chk("idle gnt",    32'(gnt),    32'h0);
      chk("idle rvalid", 32'(rvalid), 32'h0);
      chk("idle mux_a",  32'(mux_a),  32'd30);
      chk("idle rdata",  rdata,       32'hA5A5_001E);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
